instr_mem_loader: RTL

//   Boot-time program loader upstream of the CPU's instruction memory write port.
//   - Accepts a byte stream over a valid/ready handshake.
//   - Assembles little-endian 32-bit instructions and drives the InstrMEM write

---
 rtl/instr_mem_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Boot loader: assembles a length-prefixed, XOR-checksummed byte stream into
// 32-bit InstrMEM writes and releases the CPU reset once the image verifies.
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTN,
  input  logic [7:0]            i_Byte,
  input  logic                  i_Byte_Valid,
  output logic                  o_Byte_Ready,
  input  logic                  i_Restart,
  output logic [ADDR_WIDTH-1:0] o_InstrMEM_Write_Addr,
  output logic [31:0]           o_InstrMEM_Write_Instr,
  output logic                  o_InstrMEM_MemWrite,
  output logic                  o_CPU_RSTN,
  output logic                  o_Done,
  output logic                  o_Error
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]            state_q;
  logic [2:0]            state_nxt;
  logic [LEN_W-1:0]      len_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            cnt_q;
  logic [BYTE_W-1:0]     csum_q;
  logic [23:0]           lanes_q;
  logic                  ready_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORD_W-1:0]     instr_q;
  logic                  we_q;
  logic                  cpu_rstn_q;
  logic                  done_q;
  logic                  err_q;

  logic                  accept_c;
  logic [LEN_W-1:0]      len_full_c;
  logic                  len_bad_c;
  logic                  word_done_c;
  logic                  last_word_c;
  logic                  ready_nxt_c;

  assign accept_c    = i_Byte_Valid & ready_q;
  assign len_full_c  = {i_Byte, len_q[7:0]};
  assign len_bad_c   = (len_full_c == '0) || (32'(len_full_c) > 32'(DEPTH));
  assign word_done_c = accept_c && (state_q == S_DATA) && (cnt_q == 2'd3);
  assign last_word_c = (32'(idx_q) + 32'd1) == 32'(len_q);
  assign ready_nxt_c = (state_nxt == S_LEN_LO) || (state_nxt == S_LEN_HI) ||
                       (state_nxt == S_DATA)   || (state_nxt == S_CSUM);

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_LEN_LO: if (accept_c) state_nxt = S_LEN_HI;
      S_LEN_HI: if (accept_c) state_nxt = len_bad_c ? S_ERR : S_DATA;
      S_DATA:   if (word_done_c && last_word_c) state_nxt = S_CSUM;
      S_CSUM:   if (accept_c) state_nxt = (i_Byte == csum_q) ? S_DONE : S_ERR;
      S_DONE:   if (i_Restart) state_nxt = S_LEN_LO;
      S_ERR:    if (i_Restart) state_nxt = S_LEN_LO;
      default:  state_nxt = S_LEN_LO;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) state_q <= S_LEN_LO;
    else         state_q <= state_nxt;
  end

  // Status outputs are registered decodes of the next state
  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) begin
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rstn_q <= 1'b0;
    end else begin
      ready_q    <= ready_nxt_c;
      done_q     <= (state_nxt == S_DONE);
      err_q      <= (state_nxt == S_ERR);
      cpu_rstn_q <= (state_nxt == S_DONE);
    end
  end

  // Length capture, byte-lane assembly, running checksum and word writes
  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) begin
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      lanes_q <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      we_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (accept_c) begin
        case (state_q)
          S_LEN_LO: len_q[7:0] <= i_Byte;
          S_LEN_HI: begin
            len_q[15:8] <= i_Byte;
            idx_q       <= '0;
            cnt_q       <= '0;
            csum_q      <= '0;
          end
          S_DATA: begin
            csum_q <= csum_q ^ i_Byte;
            cnt_q  <= cnt_q + 2'd1;
            case (cnt_q)
              2'd0: lanes_q[7:0]   <= i_Byte;
              2'd1: lanes_q[15:8]  <= i_Byte;
              2'd2: lanes_q[23:16] <= i_Byte;
              default: begin
                addr_q  <= idx_q;
                instr_q <= {i_Byte, lanes_q};
                we_q    <= 1'b1;
                // Hold idx on the final word so a full-depth image never wraps it
                if (!last_word_c) idx_q <= idx_q + ADDR_WIDTH'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign o_Byte_Ready           = ready_q;
  assign o_InstrMEM_Write_Addr  = addr_q;
  assign o_InstrMEM_Write_Instr = instr_q;
  assign o_InstrMEM_MemWrite    = we_q;
  assign o_CPU_RSTN             = cpu_rstn_q;
  assign o_Done                 = done_q;
  assign o_Error                = err_q;

endmodule
